// File: rtl/atomrvcore_iccm_arbiter.sv
// Purpose : shares the single-port ICCM between instruction fetch (read-only) and the loader/debug port (read/write).
// Latency : grant and memory command are combinational in cycle N; the response appears in cycle N+1.
// Backpressure: requesters hold their request until granted; responses cannot be stalled.
//
// Ports:
//   clk_i, rst_ni           clock (rising edge), asynchronous active-low reset
//   boot_i                  loader owns the ICCM, fetch is blocked
//   f_req_i/f_addr_i        fetch request and byte address; f_gnt_o accepts
//   f_rvalid_o/f_rdata_o/f_err_o   fetch response
//   l_req_i/l_we_i/l_addr_i/l_wdata_i  loader request; l_gnt_o accepts
//   l_rvalid_o/l_rdata_o/l_err_o   loader response
//   mem_re_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i  ICCM port (word-indexed)
module atomrvcore_iccm_arbiter #(
    parameter int DATAWIDTH    = 32,
    parameter int ADRESS_BUS   = 20,
    parameter int MAX_LD_BURST = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  boot_i,
    input  logic                  f_req_i,
    input  logic [DATAWIDTH-1:0]  f_addr_i,
    output logic                  f_gnt_o,
    output logic                  f_rvalid_o,
    output logic [DATAWIDTH-1:0]  f_rdata_o,
    output logic                  f_err_o,
    input  logic                  l_req_i,
    input  logic                  l_we_i,
    input  logic [DATAWIDTH-1:0]  l_addr_i,
    input  logic [DATAWIDTH-1:0]  l_wdata_i,
    output logic                  l_gnt_o,
    output logic                  l_rvalid_o,
    output logic [DATAWIDTH-1:0]  l_rdata_o,
    output logic                  l_err_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    output logic [ADRESS_BUS-1:0] mem_addr_o,
    output logic [DATAWIDTH-1:0]  mem_wdata_o,
    input  logic [DATAWIDTH-1:0]  mem_rdata_i
);

    localparam logic [3:0] LP_MAX_BURST = 4'(MAX_LD_BURST);

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_FETCH  = 2'd1,
        OWN_LOADER = 2'd2
    } owner_e;

    // Word aligned and inside the 2**ADRESS_BUS word window.
    function automatic logic addr_legal(input logic [DATAWIDTH-1:0] a);
        return (a[1:0] == 2'b00) && (a[DATAWIDTH-1:ADRESS_BUS+2] == '0);
    endfunction

    owner_e     r_owner, w_owner_nxt;
    logic       r_err, w_err_nxt;
    logic       r_wr, w_wr_nxt;
    logic [3:0] r_streak, w_streak_nxt;

    logic w_f_gnt, w_l_gnt;
    logic w_f_legal, w_l_legal;
    logic w_streak_max;

    assign w_f_legal    = addr_legal(f_addr_i);
    assign w_l_legal    = addr_legal(l_addr_i);
    assign w_streak_max = (r_streak == LP_MAX_BURST);

    // Loader normally wins a collision; fetch wins once the loader has
    // taken MAX_LD_BURST consecutive grants while fetch was waiting.
    // Grants are gated by reset so nothing is accepted while held in reset.
    always_comb begin
        w_f_gnt = 1'b0;
        w_l_gnt = 1'b0;
        if (rst_ni) begin
            if (boot_i) begin
                w_l_gnt = l_req_i;
            end else if (f_req_i && l_req_i) begin
                if (w_streak_max) w_f_gnt = 1'b1;
                else              w_l_gnt = 1'b1;
            end else begin
                w_f_gnt = f_req_i;
                w_l_gnt = l_req_i;
            end
        end
    end

    assign f_gnt_o = w_f_gnt;
    assign l_gnt_o = w_l_gnt;

    // Only a legal grant touches the memory; illegal grants just produce an error response.
    always_comb begin
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_f_gnt && w_f_legal) begin
            mem_re_o    = 1'b1;
            mem_addr_o  = f_addr_i[ADRESS_BUS+1:2];
            mem_wdata_o = l_wdata_i;
        end else if (w_l_gnt && w_l_legal) begin
            mem_re_o    = ~l_we_i;
            mem_we_o    = l_we_i;
            mem_addr_o  = l_addr_i[ADRESS_BUS+1:2];
            mem_wdata_o = l_wdata_i;
        end
    end

    // Next-state for the response register and starvation counter.
    always_comb begin
        w_owner_nxt  = OWN_NONE;
        w_err_nxt    = 1'b0;
        w_wr_nxt     = 1'b0;
        w_streak_nxt = r_streak;
        if (w_f_gnt) begin
            w_owner_nxt = OWN_FETCH;
            w_err_nxt   = ~w_f_legal;
        end else if (w_l_gnt) begin
            w_owner_nxt = OWN_LOADER;
            w_err_nxt   = ~w_l_legal;
            w_wr_nxt    = l_we_i;
        end
        if (boot_i || !f_req_i || w_f_gnt) begin
            w_streak_nxt = 4'd0;
        end else if (w_l_gnt && !w_streak_max) begin
            w_streak_nxt = r_streak + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner  <= OWN_NONE;
            r_err    <= 1'b0;
            r_wr     <= 1'b0;
            r_streak <= 4'd0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_err    <= w_err_nxt;
            r_wr     <= w_wr_nxt;
            r_streak <= w_streak_nxt;
        end
    end

    // Read data is passed straight from the ICCM; writes and errors return zero.
    assign f_rvalid_o = (r_owner == OWN_FETCH);
    assign f_err_o    = f_rvalid_o & r_err;
    assign f_rdata_o  = (f_rvalid_o && !r_err) ? mem_rdata_i : '0;

    assign l_rvalid_o = (r_owner == OWN_LOADER);
    assign l_err_o    = l_rvalid_o & r_err;
    assign l_rdata_o  = (l_rvalid_o && !r_err && !r_wr) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_atomrvcore_iccm_arbiter.sv
module tb_atomrvcore_iccm_arbiter;

    localparam int DW  = 32;
    localparam int AB  = 20;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          rst_n, boot;
    logic          f_req, l_req, l_we;
    logic [DW-1:0] f_addr, l_addr, l_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          f_gnt_o, f_rvalid_o, f_err_o;
    logic [DW-1:0] f_rdata_o;
    logic          l_gnt_o, l_rvalid_o, l_err_o;
    logic [DW-1:0] l_rdata_o;
    logic          mem_re_o, mem_we_o;
    logic [AB-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;

    int n_cmp = 0;
    int n_bad = 0;

    atomrvcore_iccm_arbiter #(.DATAWIDTH(DW), .ADRESS_BUS(AB), .MAX_LD_BURST(MAX)) dut (
        .clk_i(clk), .rst_ni(rst_n), .boot_i(boot),
        .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt_o),
        .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o), .f_err_o(f_err_o),
        .l_req_i(l_req), .l_we_i(l_we), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
        .l_gnt_o(l_gnt_o), .l_rvalid_o(l_rvalid_o), .l_rdata_o(l_rdata_o), .l_err_o(l_err_o),
        .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // ICCM behaviour: synchronous write, one-cycle read; garbage on the bus when idle.
    logic [DW-1:0] iccm [int];
    always @(posedge clk) begin
        if (mem_we_o) iccm[int'(mem_addr_o)] = mem_wdata_o;
        if (mem_re_o) mem_rdata <= iccm.exists(int'(mem_addr_o)) ? iccm[int'(mem_addr_o)] : '0;
        else          mem_rdata <= $urandom;
    end

    // Reference model state: expected memory contents, starvation count, pending response.
    logic [DW-1:0] ref_mem [int];
    int            m_streak = 0;
    int            p_owner = 0;       // 0 none, 1 fetch, 2 loader
    bit            p_err = 1'b0;
    logic [DW-1:0] p_rdata = '0;
    bit            efg = 1'b0, elg = 1'b0;

    function automatic bit legal(input logic [DW-1:0] a);
        return (a % 4 == 0) && (a < (32'd1 << (AB + 2)));
    endfunction

    function automatic logic [DW-1:0] mrd(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : '0;
    endfunction

    function automatic logic [DW-1:0] env_rd(input int idx);
        return iccm.exists(idx) ? iccm[idx] : '0;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Predict this cycle's grants/memory command and compare, then advance the model.
    task automatic check_cycle();
        bit fl, ll, e_re, e_we;
        logic [DW-1:0] e_addr;
        efg = 1'b0;
        elg = 1'b0;
        if (rst_n) begin
            if (boot) elg = l_req;
            else if (f_req && l_req) begin
                if (m_streak == MAX) efg = 1'b1;
                else                 elg = 1'b1;
            end else begin
                efg = f_req;
                elg = l_req;
            end
        end
        fl = legal(f_addr);
        ll = legal(l_addr);
        e_re = 1'b0; e_we = 1'b0; e_addr = '0;
        if (efg && fl) begin
            e_re = 1'b1; e_addr = f_addr >> 2;
        end else if (elg && ll) begin
            e_re = !l_we; e_we = l_we; e_addr = l_addr >> 2;
        end
        chk("f_gnt", f_gnt_o, efg);
        chk("l_gnt", l_gnt_o, elg);
        chk("mem_re", mem_re_o, e_re);
        chk("mem_we", mem_we_o, e_we);
        chk("mem_addr", 32'(mem_addr_o), e_addr);
        if (e_we || !e_re) chk("mem_wdata", mem_wdata_o, e_we ? l_wdata : '0);
        chk("f_rvalid", f_rvalid_o, p_owner == 1);
        chk("f_err", f_err_o, p_owner == 1 && p_err);
        chk("f_rdata", f_rdata_o, p_owner == 1 ? p_rdata : '0);
        chk("l_rvalid", l_rvalid_o, p_owner == 2);
        chk("l_err", l_err_o, p_owner == 2 && p_err);
        chk("l_rdata", l_rdata_o, p_owner == 2 ? p_rdata : '0);
        if (!rst_n) begin
            p_owner = 0; m_streak = 0;
        end else begin
            if (efg) begin
                p_owner = 1; p_err = !fl;
                p_rdata = fl ? mrd(int'(f_addr >> 2)) : '0;
            end else if (elg) begin
                p_owner = 2; p_err = !ll;
                p_rdata = (ll && !l_we) ? mrd(int'(l_addr >> 2)) : '0;
                if (ll && l_we) ref_mem[int'(l_addr >> 2)] = l_wdata;
            end else begin
                p_owner = 0;
            end
            if (boot || !f_req || efg) m_streak = 0;
            else if (elg && m_streak < MAX) m_streak++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8)       return 32'($urandom_range(0, 15) * 4);
        else if (r == 8) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else             return (32'd1 << (AB + 2)) | 32'($urandom_range(0, 15) * 4);
    endfunction

    initial begin
        rst_n = 1'b0; boot = 1'b0;
        f_req = 1'b0; f_addr = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;

        // Reset, then idle after release
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Boot load: fetch blocked while loader fills words 0 and 1
        boot = 1'b1; f_req = 1'b1; f_addr = 32'h4;
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h0; l_wdata = 32'hDEADBEEF;
        #1;
        chk("boot_we0", mem_we_o, 1'b1);
        chk("boot_addr0", 32'(mem_addr_o), 32'd0);
        tick();
        l_addr = 32'h4; l_wdata = 32'h00000013;
        #1;
        chk("boot_addr1", 32'(mem_addr_o), 32'd1);
        chk("boot_ack0", {l_rvalid_o, l_err_o}, 2'b10);
        tick();
        l_req = 1'b0;
        #1;
        chk("boot_ack1", {l_rvalid_o, l_err_o}, 2'b10);
        tick();

        // Fetch read of 0x4
        boot = 1'b0;
        #1;
        chk("fetch_re", {mem_re_o, 32'(mem_addr_o)}, {1'b1, 32'd1});
        tick();
        f_req = 1'b0;
        #1;
        chk("fetch_rdata", f_rdata_o, 32'h00000013);
        tick();

        // Starvation pattern L,L,L,L,F,...
        tick();
        f_req = 1'b1; f_addr = 32'h4;
        l_req = 1'b1; l_we = 1'b0; l_addr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("starve_f", f_gnt_o, (i % 5) == 4);
            tick();
        end

        // Illegal accesses: misaligned fetch, out-of-range loader write
        l_req = 1'b0; f_addr = 32'h6;
        #1;
        chk("ill_f_nomem", {f_gnt_o, mem_re_o, mem_we_o}, 3'b100);
        tick();
        f_req = 1'b0;
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'd1 << (AB + 2); l_wdata = 32'hFFFFFFFF;
        #1;
        chk("ill_f_resp", {f_rvalid_o, f_err_o, f_rdata_o}, {2'b11, 32'h0});
        chk("ill_l_nomem", {l_gnt_o, mem_re_o, mem_we_o}, 3'b100);
        tick();
        l_req = 1'b0;
        #1;
        chk("ill_l_resp", {l_rvalid_o, l_err_o, l_rdata_o}, {2'b11, 32'h0});
        chk("ill_mem0", env_rd(0), 32'hDEADBEEF);
        chk("ill_mem1", env_rd(1), 32'h00000013);
        tick();

        // Write then read back-to-back
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h10; l_wdata = 32'hA5A5A5A5;
        tick();
        l_we = 1'b0;
        tick();
        l_req = 1'b0;
        #1;
        chk("wr_rd", l_rdata_o, 32'hA5A5A5A5);
        tick();

        // Reset in the middle of a pending response
        l_req = 1'b1; l_we = 1'b0; l_addr = 32'h10;
        f_req = 1'b1; f_addr = 32'h0;
        tick();
        rst_n = 1'b0;
        p_owner = 0; m_streak = 0;
        #1;
        check_cycle();
        repeat (2) tick();
        rst_n = 1'b1;
        f_req = 1'b0; l_req = 1'b0;
        repeat (2) tick();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            if (!f_req || efg) begin
                f_req = ($urandom_range(0, 2) != 0);
                f_addr = rnd_addr();
            end
            if (!l_req || elg) begin
                l_req = 1'($urandom_range(0, 1));
                l_we = 1'($urandom_range(0, 1));
                l_addr = rnd_addr();
                l_wdata = $urandom;
            end
            if ($urandom_range(0, 15) == 0) boot = !boot;
            tick();
        end
        foreach (ref_mem[k]) chk("final_mem", env_rd(k), ref_mem[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
